// File: rtl/bus_rr_arbiter_if.sv
// Transmit-FIFO heads and receive strobes between the shared-bus devices and the arbiter.
interface bus_rr_arbiter_if #(
    parameter int devices = 4,
    parameter int width   = 16
);
    logic [devices-1:0]       pndng;
    logic [devices*width-1:0] D_pop;
    logic [devices-1:0]       pop;
    logic [devices-1:0]       push;
    logic [width-1:0]         D_push;
    logic [7:0]               grant_id;
    logic                     busy;
    logic [15:0]              drop_cnt;

    modport master (
        input  pndng, D_pop,
        output pop, push, D_push, grant_id, busy, drop_cnt
    );

    modport slave (
        output pndng, D_pop,
        input  pop, push, D_push, grant_id, busy, drop_cnt
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter/router: pops one word from a granted device FIFO and pushes it
// to the addressed device (or all other devices on broadcast).
//
// state   | meaning
// IDLE    | waiting for any pndng; picks next source from rr_ptr
// GRANT   | pop strobe to source, word latched into D_push
// DELIVER | push strobe(s) to destination(s) or drop; rr_ptr advances
module bus_rr_arbiter #(
    parameter int         devices   = 4,
    parameter int         width     = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input logic         clk,
    input logic         rst_n,
    bus_rr_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, GRANT, DELIVER} state_t;

    state_t             state_q, state_d;
    logic [7:0]         src_q, src_d;
    logic [7:0]         rr_ptr_q, rr_ptr_d;
    logic [width-1:0]   d_push_q, d_push_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic [devices-1:0] pop, push;
    logic [devices-1:0] src_onehot;
    logic [7:0]         dest;
    logic [7:0]         pick;
    logic               pick_vld;
    logic [8:0]         idx;

    assign dest       = d_push_q[width-1 -: 8];
    assign src_onehot = devices'(1) << src_q;

    // Downward scan so the smallest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = devices - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + 9'(k);
            if (idx >= 9'(devices)) idx = idx - 9'(devices);
            if (|(bus.pndng & (devices'(1) << idx))) begin
                pick     = idx[7:0];
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        rr_ptr_d   = rr_ptr_q;
        d_push_d   = d_push_q;
        drop_cnt_d = drop_cnt_q;
        pop        = '0;
        push       = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    src_d   = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                pop      = src_onehot;
                d_push_d = width'(bus.D_pop >> (32'(src_q) * width));
                state_d  = DELIVER;
            end
            DELIVER: begin
                if (dest < 8'(devices) && dest != src_q) begin
                    push = devices'(1) << dest;
                end else if (dest == broadcast) begin
                    push = ~src_onehot;
                end else if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
                rr_ptr_d = (src_q == 8'(devices - 1)) ? 8'd0 : src_q + 8'd1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_q      <= '0;
            rr_ptr_q   <= '0;
            d_push_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            rr_ptr_q   <= rr_ptr_d;
            d_push_q   <= d_push_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.pop      = pop;
    assign bus.push     = push;
    assign bus.D_push   = d_push_q;
    assign bus.grant_id = src_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: vector table of single transfers plus
// round-robin and reset-during-delivery sequences.
module tb_bus_rr_arbiter;

    logic clk;
    logic rst_n;

    bus_rr_arbiter_if #(.devices(4), .width(16)) bus ();

    bus_rr_arbiter #(.devices(4), .width(16), .broadcast(8'hFF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pndng;
        logic [63:0] words;
        logic [7:0]  gid;
        logic [3:0]  pop;
        logic [3:0]  push;
        logic [15:0] dpush;
        logic [15:0] drop;
    } vec_t;

    vec_t vecs [8];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    int npop, npush, cyc, last_pop_cyc, last_src, p;
    logic seen;

    initial begin
        // Table rows: words are {dev3, dev2, dev1, dev0}; 16'hEEEE is filler never forwarded.
        vecs[0] = '{4'b0010, {16'hEEEE, 16'hEEEE, 16'h02AB, 16'hEEEE}, 8'd1, 4'b0010, 4'b0100, 16'h02AB, 16'd0};
        vecs[1] = '{4'b0001, {16'hEEEE, 16'hEEEE, 16'hEEEE, 16'hFFCD}, 8'd0, 4'b0001, 4'b1110, 16'hFFCD, 16'd0};
        vecs[2] = '{4'b1000, {16'h0711, 16'hEEEE, 16'hEEEE, 16'hEEEE}, 8'd3, 4'b1000, 4'b0000, 16'h0711, 16'd1};
        vecs[3] = '{4'b0100, {16'hEEEE, 16'h0255, 16'hEEEE, 16'hEEEE}, 8'd2, 4'b0100, 4'b0000, 16'h0255, 16'd2};
        vecs[4] = '{4'b0011, {16'hEEEE, 16'hEEEE, 16'hEEEE, 16'h0333}, 8'd0, 4'b0001, 4'b1000, 16'h0333, 16'd2};
        vecs[5] = '{4'b0101, {16'hEEEE, 16'h0100, 16'hEEEE, 16'hEEEE}, 8'd2, 4'b0100, 4'b0010, 16'h0100, 16'd2};
        vecs[6] = '{4'b1001, {16'h0000, 16'hEEEE, 16'hEEEE, 16'hEEEE}, 8'd3, 4'b1000, 4'b0001, 16'h0000, 16'd2};
        vecs[7] = '{4'b0010, {16'hEEEE, 16'hEEEE, 16'h04AA, 16'hEEEE}, 8'd1, 4'b0010, 4'b0000, 16'h04AA, 16'd3};

        // Reset with random inputs
        rst_n     = 1'b0;
        bus.pndng = '0;
        bus.D_pop = '0;
        for (int i = 0; i < 3; i++) begin
            bus.pndng = 4'($urandom);
            bus.D_pop = {$urandom, $urandom};
            step();
        end
        chk("rst_pop",      bus.pop,      0);
        chk("rst_push",     bus.push,     0);
        chk("rst_dpush",    bus.D_push,   0);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_drop",     bus.drop_cnt, 0);
        bus.pndng = '0;
        #3 rst_n = 1'b1;
        step(); step(); step();
        chk("rel_busy", bus.busy, 0);
        chk("rel_pop",  bus.pop,  0);
        chk("rel_push", bus.push, 0);

        // Single-transfer vectors; rr_ptr carries over from row to row.
        for (int v = 0; v < 8; v++) begin
            bus.pndng = vecs[v].pndng;
            bus.D_pop = vecs[v].words;
            step();
            chk($sformatf("v%0d_grant_pop", v),  bus.pop,      vecs[v].pop);
            chk($sformatf("v%0d_grant_busy", v), bus.busy,     1);
            chk($sformatf("v%0d_grant_id", v),   bus.grant_id, vecs[v].gid);
            bus.pndng = '0;
            step();
            chk($sformatf("v%0d_dlv_push", v),  bus.push,   vecs[v].push);
            chk($sformatf("v%0d_dlv_dpush", v), bus.D_push, vecs[v].dpush);
            chk($sformatf("v%0d_dlv_pop", v),   bus.pop,    0);
            chk($sformatf("v%0d_dlv_busy", v),  bus.busy,   1);
            step();
            chk($sformatf("v%0d_idle_push", v),  bus.push,     0);
            chk($sformatf("v%0d_idle_busy", v),  bus.busy,     0);
            chk($sformatf("v%0d_idle_drop", v),  bus.drop_cnt, vecs[v].drop);
            chk($sformatf("v%0d_idle_dpush", v), bus.D_push,   vecs[v].dpush);
        end

        // Round-robin with all devices pending, each addressing (src+1) mod 4
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        bus.pndng = 4'b1111;
        bus.D_pop = {16'h0000, 16'h0300, 16'h0200, 16'h0100};
        npop = 0; npush = 0; last_pop_cyc = 0; last_src = 0;
        for (cyc = 0; cyc < 30 && npush < 5; cyc++) begin
            step();
            if (bus.pop != 0 && npop < 5) begin
                chk($sformatf("rr_pop%0d", npop), bus.pop, 4'b0001 << order[npop]);
                chk($sformatf("rr_gid%0d", npop), bus.grant_id, order[npop]);
                if (npop > 0) chk($sformatf("rr_spacing%0d", npop), cyc - last_pop_cyc, 3);
                last_pop_cyc = cyc;
                last_src     = order[npop];
                npop++;
            end
            if (bus.push != 0) begin
                chk($sformatf("rr_push%0d", npush), bus.push, 4'b0001 << ((last_src + 1) % 4));
                chk($sformatf("rr_lag%0d", npush), cyc - last_pop_cyc, 1);
                npush++;
            end
        end
        bus.pndng = '0;
        chk("rr_pop_count",  npop,  5);
        chk("rr_push_count", npush, 5);
        step();

        // Device 2 completes (rr_ptr -> 3), then device 3 is reset mid-DELIVER
        bus.pndng = 4'b0100;
        bus.D_pop = {16'hEEEE, 16'h0300, 16'hEEEE, 16'hEEEE};
        step();
        chk("pre_pop", bus.pop, 4'b0100);
        bus.pndng = '0;
        step();
        chk("pre_push", bus.push, 4'b1000);
        step();
        bus.pndng = 4'b1000;
        bus.D_pop = {16'h0000, 16'hEEEE, 16'hEEEE, 16'hEEEE};
        step();
        chk("mid_pop", bus.pop, 4'b1000);
        bus.pndng = '0;
        step();
        chk("mid_push_before", bus.push, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("mid_push_dropped", bus.push, 0);
        chk("mid_busy_dropped", bus.busy, 0);
        bus.pndng = 4'b1100;
        bus.D_pop = {16'h0200, 16'h0100, 16'hEEEE, 16'hEEEE};
        #3 rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            step();
            if (bus.pop != 0) begin
                seen = 1'b1;
                chk("post_rst_pop", bus.pop, 4'b0100);
                chk("post_rst_gid", bus.grant_id, 2);
            end
        end
        chk("post_rst_seen", seen, 1);
        bus.pndng = '0;
        step(); step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin arbiter and router for the shared multi-device bus. Each of `devices` agents exposes a show-ahead transmit FIFO head (`pndng`, `D_pop`, `pop`). The arbiter grants one source at a time, pops one word, decodes the destination ID in the word's upper byte, and pushes the word into the receive side of the addressed device, or of every other device for broadcast. It sits between the device FIFOs and the bus, replacing any free-running bus model, and is the single owner of all `pop`/`push` strobes.

## Interface
- `devices`, 4: number of attached devices; 2..255.
- `width`, 16: word width in bits; must be > 8.
- `broadcast`, 8'hFF: destination ID meaning "all devices except source".
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `pndng`  input  devices  bit i = device i FIFO non-empty.
- `D_pop`  input  devices*width  word i at bits [i*width +: width]; FIFO head, valid while `pndng[i]`.
- `pop`  output  devices  one-cycle consume strobe to device i.
- `push`  output  devices  one-cycle deliver strobe to device i.
- `D_push`  output  width  delivered word, common to all receivers.
- `grant_id`  output  8  ID of the source currently being serviced.
- `busy`  output  1  high in GRANT and DELIVER.
- `drop_cnt`  output  16  count of discarded words; saturates at 16'hFFFF.

## Operation
- Word format:
  - dest = `D[width-1 -: 8]`.
  - payload = `D[width-9:0]`.
  - The word is forwarded unmodified.
- FSM states: IDLE, GRANT, DELIVER.
  - IDLE: if `|pndng`, select the first set bit searching upward from `rr_ptr`, wrapping at `devices-1`. Register it into `src` and `grant_id`, then go to GRANT. Otherwise stay in IDLE.
  - GRANT: `pop[src]`=1 for exactly this cycle. Latch `D_pop[src]` into `D_push` and decode dest. Go to DELIVER.
  - DELIVER:
    - dest < devices and dest != src: `push[dest]`=1.
    - dest == broadcast: `push` = all ones except bit `src`.
    - Otherwise (dest ≥ devices and not broadcast, or dest == src): no push, and `drop_cnt` increments.
    - Then `rr_ptr` = (src+1) mod `devices`, go to IDLE.
- `pndng` is sampled only in IDLE. A source deasserting `pndng` after grant does not cancel the transfer.
- At most one `pop` bit is high in any cycle. `push` is high only in DELIVER.
- `D_push` holds its last delivered word between transfers.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, `rr_ptr`=0.
  - `pop`=0, `push`=0, `D_push`=0, `grant_id`=0, `busy`=0, `drop_cnt`=0.
- Latency: `pndng` seen high at IDLE edge N, then `pop` high in cycle N+1, then `push` high in cycle N+2.
- Throughput: one word per 3 cycles. Back-to-back requests pass through IDLE between transfers.
- `busy` is high in cycles N+1 and N+2.
- Reset asserted mid-GRANT or mid-DELIVER: strobes drop immediately (asynchronously) and the word in flight is lost. After release, arbitration restarts from device 0.
- Simultaneous requests: exactly one is granted per IDLE decision. Every continuously pending device is serviced within `devices` transfers.
- `drop_cnt` at 16'hFFFF stays at 16'hFFFF on further drops.

## Test plan
- Reset check: hold `rst_n`=0 with random inputs. All outputs read 0. Release with `pndng`=0: outputs stay 0 and `busy`=0.
- Unicast: `pndng`=4'b0010, `D_pop[1]`=16'h02AB.
  - `pop`=4'b0010 one cycle later.
  - Next cycle `push`=4'b0100, `D_push`=16'h02AB, `grant_id`=1.
  - No further strobes.
- Broadcast: device 0 word 16'hFFCD. Required: `pop`=4'b0001, then `push`=4'b1110 with `D_push`=16'hFFCD.
- Round-robin: all four `pndng` held high, each word addressed to (src+1) mod 4. Required grant order is 0,1,2,3,0, and each pop→push pair is 3 cycles apart.
- Drops:
  - Device 3 sends 16'h0711: `pop[3]` fires, no push, `drop_cnt`=1.
  - Device 2 sends 16'h0255 (self-addressed): no push, `drop_cnt`=2.
- Reset mid-DELIVER: assert `rst_n`=0 during the `push` cycle. `push` goes to 0 before the next edge. After release with `pndng`=4'b1100, device 2 is granted first.
